// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the 640x480@60 Hz VGA mode and the 2-bit phase
// encodings used by the horizontal and vertical raster FSMs. Imported by the
// raster timing generator and by the display top.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal geometry, in pixels.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // Vertical geometry, in lines.
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // One encoding serves both axes; the aliases below give each FSM its own names.
    typedef enum logic [1:0] {
        PH_ACT   = 2'd0,
        PH_FRONT = 2'd1,
        PH_SYNCP = 2'd2,
        PH_BACK  = 2'd3
    } phase_e;

    localparam phase_e H_ACT   = PH_ACT;
    localparam phase_e H_FRONT = PH_FRONT;
    localparam phase_e H_SYNCP = PH_SYNCP;
    localparam phase_e H_BACK  = PH_BACK;

    localparam phase_e V_ACT   = PH_ACT;
    localparam phase_e V_FRONT = PH_FRONT;
    localparam phase_e V_SYNCP = PH_SYNCP;
    localparam phase_e V_BACK  = PH_BACK;

    // Period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned phase_total(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// -----------------------------------------------------------------------------
// vga_phase_counter
// One raster axis: a free-running counter 0..TOTAL-1, its phase FSM
// (active / front porch / sync / back porch) and the sync decode. Exposes the
// next-state values so the parent can register aligned outputs on the same
// edge the counter moves.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (counter -> TOTAL-1, phase -> BACK)
//   step         advance the counter by one on this clock edge
//   wrap         counter currently holds TOTAL-1 (next step returns to 0)
//   o_cnt_next   counter value after this edge
//   o_phase_next phase after this edge
//   o_sync_next  sync level after this edge (SYNC_POL while in the sync phase)
// -----------------------------------------------------------------------------
module vga_phase_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned FP       = VGA_H_FP,
    parameter int unsigned SYNC     = VGA_H_SYNC,
    parameter int unsigned BP       = VGA_H_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CW       = $clog2(phase_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic          wrap,
    output logic [CW-1:0] o_cnt_next,
    output phase_e        o_phase_next,
    output logic          o_sync_next
);

    localparam int unsigned   TOTAL     = phase_total(ACTIVE, FP, SYNC, BP);
    // Last count of each phase; the step off that count enters the next phase.
    localparam logic [CW-1:0] LAST_ACT  = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] LAST_FP   = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] LAST_SYNC = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(TOTAL - 1);

    logic [CW-1:0] r_cnt;
    phase_e        r_phase;
    logic [CW-1:0] w_cnt_next;
    phase_e        w_phase_next;

    assign wrap = (r_cnt == LAST_CNT);

    always_comb begin : next_state
        // NOTE: defaults first so every path assigns both signals; a missing
        // else on the hold path would otherwise infer a latch.
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        if (step) begin
            w_cnt_next = wrap ? '0 : r_cnt + CW'(1);
            if (r_cnt == LAST_ACT) begin
                w_phase_next = PH_FRONT;
            end else if (r_cnt == LAST_FP) begin
                w_phase_next = PH_SYNCP;
            end else if (r_cnt == LAST_SYNC) begin
                w_phase_next = PH_BACK;
            end else if (wrap) begin
                w_phase_next = PH_ACT;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_cnt   <= LAST_CNT;
            r_phase <= PH_BACK;
        end else begin
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
        end
    end

    assign o_cnt_next   = w_cnt_next;
    assign o_phase_next = w_phase_next;
    assign o_sync_next  = (w_phase_next == PH_SYNCP) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster timing generator: horizontal and vertical phase counters advanced by
// a pixel-rate enable, with position, blanking, sync and frame-start outputs
// registered together so they always describe the same pixel.
//
// Ports:
//   clk          system clock (only clock)
//   rst          synchronous active-high reset
//   pix_en       pixel-rate enable; counters advance only when 1
//   x_pos        current row (vertical line index), 0 outside the active area
//   y_pos        current column (pixel index), 0 outside the active area
//   video_on     1 inside the active area
//   hsync        horizontal sync, SYNC_POL when asserted
//   vsync        vertical sync, SYNC_POL when asserted
//   frame_start  one-clk pulse after the enable that enters pixel (0,0)
// -----------------------------------------------------------------------------
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned X_BITS   = 8,
    parameter int unsigned Y_BITS   = 9,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_en,
    output logic [X_BITS:0] x_pos,
    output logic [Y_BITS:0] y_pos,
    output logic            video_on,
    output logic            hsync,
    output logic            vsync,
    output logic            frame_start
);

    localparam int unsigned H_TOTAL = phase_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = phase_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    // Counters are sized for the totals; positions are truncated to port width.
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);

    logic [HCW-1:0]  w_h_cnt_next;
    logic [VCW-1:0]  w_v_cnt_next;
    phase_e          w_h_phase_next;
    phase_e          w_v_phase_next;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic            w_v_step;
    logic            w_hsync_next;
    logic            w_vsync_next;
    logic            w_video_next;
    logic            w_frame_enter;
    logic [X_BITS:0] w_x_next;
    logic [Y_BITS:0] w_y_next;

    logic [X_BITS:0] r_x_pos;
    logic [Y_BITS:0] r_y_pos;
    logic            r_video_on;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_frame_start;

    vga_phase_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL),
        .CW       (HCW)
    ) u_h (
        .clk          (clk),
        .rst          (rst),
        .step         (pix_en),
        .wrap         (w_h_wrap),
        .o_cnt_next   (w_h_cnt_next),
        .o_phase_next (w_h_phase_next),
        .o_sync_next  (w_hsync_next)
    );

    // The vertical axis moves only on the enable where the line wraps, so
    // vsync edges coincide with the edge that takes h_cnt to 0.
    assign w_v_step = w_h_wrap & pix_en;

    vga_phase_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL),
        .CW       (VCW)
    ) u_v (
        .clk          (clk),
        .rst          (rst),
        .step         (w_v_step),
        .wrap         (w_v_wrap),
        .o_cnt_next   (w_v_cnt_next),
        .o_phase_next (w_v_phase_next),
        .o_sync_next  (w_vsync_next)
    );

    // Both counters at their last value on an enable means this edge lands on
    // (0,0); gating with pix_en keeps the pulse one clk wide between enables.
    assign w_frame_enter = pix_en & w_h_wrap & w_v_wrap;
    assign w_video_next  = (w_h_phase_next == H_ACT) && (w_v_phase_next == V_ACT);
    assign w_x_next      = w_video_next ? (X_BITS+1)'(w_v_cnt_next) : '0;
    assign w_y_next      = w_video_next ? (Y_BITS+1)'(w_h_cnt_next) : '0;

    always_ff @(posedge clk) begin : out_reg
        if (rst) begin
            r_x_pos       <= '0;
            r_y_pos       <= '0;
            r_video_on    <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_x_pos       <= w_x_next;
            r_y_pos       <= w_y_next;
            r_video_on    <= w_video_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_frame_start <= w_frame_enter;
        end
    end

    assign x_pos       = r_x_pos;
    assign y_pos       = r_y_pos;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Drives two generators from one stimulus stream: the default 640x480 mode and
// a shrunken 32x19 mode with positive sync polarity, so that whole frames fit
// in a short run. The driver pushes per-cycle expectations (from a pixel-index
// formula) and hand-computed directed vectors into queues; a monitor on the
// falling edge pops and compares against both instances.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    typedef struct packed {
        logic [8:0] x;
        logic [9:0] y;
        logic       video;
        logic       hs;
        logic       vs;
        logic       fs;
    } out_t;

    typedef struct packed {
        int ha; int hfp; int hsl; int hbp;
        int va; int vfp; int vsl; int vbp;
        bit pol;
    } geom_t;

    typedef struct {
        int   cyc;
        out_t d;
        out_t s;
    } mdl_t;

    typedef struct {
        int    cyc;
        bit    inst;   // 0 = default mode, 1 = small mode
        string name;
        out_t  e;
    } dir_t;

    localparam geom_t G_D = '{ha:640, hfp:16, hsl:96, hbp:48, va:480, vfp:10, vsl:2, vbp:33, pol:1'b0};
    localparam geom_t G_S = '{ha:16,  hfp:4,  hsl:6,  hbp:6,  va:12,  vfp:2,  vsl:2, vbp:3,  pol:1'b1};
    localparam int FD = 800 * 525;
    localparam int FS = 32 * 19;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b1;

    logic [8:0] d_x, s_x;
    logic [9:0] d_y, s_y;
    logic       d_video, d_hs, d_vs, d_fs;
    logic       s_video, s_hs, s_vs, s_fs;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   p_d      = FD - 1;
    int   p_s      = FS - 1;
    mdl_t mdl_q[$];
    dir_t dir_q[$];

    always #5 clk = ~clk;

    vga_timing u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .x_pos(d_x), .y_pos(d_y), .video_on(d_video),
        .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_timing #(
        .X_BITS(8), .Y_BITS(9),
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .x_pos(s_x), .y_pos(s_y), .video_on(s_video),
        .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic string fmt(input out_t a, input out_t e);
        return $sformatf("got x=%0d y=%0d video=%b hs=%b vs=%b fs=%b, expected x=%0d y=%0d video=%b hs=%b vs=%b fs=%b",
                         a.x, a.y, a.video, a.hs, a.vs, a.fs, e.x, e.y, e.video, e.hs, e.vs, e.fs);
    endfunction

    // Expected outputs for linear pixel index p within the frame.
    function automatic out_t expect_px(input geom_t g, input int p, input bit fs_edge);
        out_t o;
        int   ht;
        int   col;
        int   row;
        bit   in_hs;
        bit   in_vs;
        ht    = g.ha + g.hfp + g.hsl + g.hbp;
        col   = p % ht;
        row   = p / ht;
        in_hs = (col >= g.ha + g.hfp) && (col < g.ha + g.hfp + g.hsl);
        in_vs = (row >= g.va + g.vfp) && (row < g.va + g.vfp + g.vsl);
        o.video = (col < g.ha) && (row < g.va);
        o.x     = o.video ? 9'(row) : 9'd0;
        o.y     = o.video ? 10'(col) : 10'd0;
        o.hs    = in_hs ? g.pol : ~g.pol;
        o.vs    = in_vs ? g.pol : ~g.pol;
        o.fs    = fs_edge && (p == 0);
        return o;
    endfunction

    task automatic add_dir(input int c, input bit inst, input string nm, input int x, input int y,
                           input bit v, input bit h, input bit vv, input bit f);
        dir_t d;
        d.cyc     = c;
        d.inst    = inst;
        d.name    = nm;
        d.e.x     = 9'(x);
        d.e.y     = 10'(y);
        d.e.video = v;
        d.e.hs    = h;
        d.e.vs    = vv;
        d.e.fs    = f;
        dir_q.push_back(d);
    endtask

    // One clock: drive inputs after the falling edge, then record what the
    // outputs must show after the rising edge.
    task automatic tick(input bit r, input bit e);
        mdl_t m;
        @(negedge clk);
        rst    = r;
        pix_en = e;
        @(posedge clk);
        cyc++;
        if (r) begin
            p_d = FD - 1;
            p_s = FS - 1;
        end else if (e) begin
            p_d = (p_d + 1) % FD;
            p_s = (p_s + 1) % FS;
        end
        m.cyc = cyc;
        m.d   = expect_px(G_D, p_d, !r && e);
        m.s   = expect_px(G_S, p_s, !r && e);
        mdl_q.push_back(m);
    endtask

    // Monitor: compares away from the active edge.
    mdl_t mon_m;
    dir_t mon_d;
    out_t act_d;
    out_t act_s;
    out_t act;

    always @(negedge clk) begin
        if (mdl_q.size() > 0) begin
            mon_m = mdl_q.pop_front();
            act_d = {d_x, d_y, d_video, d_hs, d_vs, d_fs};
            act_s = {s_x, s_y, s_video, s_hs, s_vs, s_fs};
            check($sformatf("model_default@%0d", mon_m.cyc), act_d === mon_m.d,
                  (act_d === mon_m.d) ? "" : fmt(act_d, mon_m.d));
            check($sformatf("model_small@%0d", mon_m.cyc), act_s === mon_m.s,
                  (act_s === mon_m.s) ? "" : fmt(act_s, mon_m.s));
            while (dir_q.size() > 0 && dir_q[0].cyc <= mon_m.cyc) begin
                mon_d = dir_q.pop_front();
                act   = mon_d.inst ? act_s : act_d;
                if (mon_d.cyc == mon_m.cyc) begin
                    check(mon_d.name, act === mon_d.e, (act === mon_d.e) ? "" : fmt(act, mon_d.e));
                end else begin
                    check(mon_d.name, 1'b0, $sformatf("vector for cycle %0d never sampled", mon_d.cyc));
                end
            end
        end
    end

    initial begin
        int n;

        // Directed vectors, in cycle order. Cycle 4 is the first enable after reset.
        add_dir(1,    0, "rst_d",          0, 0,   0, 1, 1, 0);
        add_dir(1,    1, "rst_s",          0, 0,   0, 0, 0, 0);
        add_dir(3,    0, "rst_hold_d",     0, 0,   0, 1, 1, 0);
        add_dir(3,    1, "rst_hold_s",     0, 0,   0, 0, 0, 0);
        add_dir(4,    0, "first_px_d",     0, 0,   1, 1, 1, 1);
        add_dir(4,    1, "first_px_s",     0, 0,   1, 0, 0, 1);
        add_dir(5,    0, "second_px_d",    0, 1,   1, 1, 1, 0);
        add_dir(5,    1, "second_px_s",    0, 1,   1, 0, 0, 0);
        add_dir(23,   1, "s_pre_hsync",    0, 0,   0, 0, 0, 0);
        add_dir(24,   1, "s_hsync_on",     0, 0,   0, 1, 0, 0);
        add_dir(29,   1, "s_hsync_last",   0, 0,   0, 1, 0, 0);
        add_dir(30,   1, "s_hsync_off",    0, 0,   0, 0, 0, 0);
        add_dir(371,  1, "s_corner",       11, 15, 1, 0, 0, 0);
        add_dir(372,  1, "s_after_corner", 0, 0,   0, 0, 0, 0);
        add_dir(451,  1, "s_pre_vsync",    0, 0,   0, 0, 0, 0);
        add_dir(452,  1, "s_vsync_on",     0, 0,   0, 0, 1, 0);
        add_dir(515,  1, "s_vsync_last",   0, 0,   0, 0, 1, 0);
        add_dir(516,  1, "s_vsync_off",    0, 0,   0, 0, 0, 0);
        add_dir(612,  1, "s_frame2",       0, 0,   1, 0, 0, 1);
        add_dir(613,  1, "s_frame2_next",  0, 1,   1, 0, 0, 0);
        add_dir(643,  0, "d_last_active",  0, 639, 1, 1, 1, 0);
        add_dir(644,  0, "d_first_blank",  0, 0,   0, 1, 1, 0);
        add_dir(659,  0, "d_pre_hsync",    0, 0,   0, 1, 1, 0);
        add_dir(660,  0, "d_hsync_on",     0, 0,   0, 0, 1, 0);
        add_dir(755,  0, "d_hsync_last",   0, 0,   0, 0, 1, 0);
        add_dir(756,  0, "d_hsync_off",    0, 0,   0, 1, 1, 0);
        add_dir(804,  0, "d_line1",        1, 0,   1, 1, 1, 0);
        add_dir(1220, 1, "s_frame3",       0, 0,   1, 0, 0, 1);
        add_dir(1604, 0, "d_line2",        2, 0,   1, 1, 1, 0);
        add_dir(1900, 1, "s_gated_fs",     0, 0,   1, 0, 0, 1);
        add_dir(1901, 1, "s_gated_fs_w",   0, 0,   1, 0, 0, 0);
        add_dir(1903, 1, "s_gated_hold",   0, 0,   1, 0, 0, 0);
        add_dir(1904, 1, "s_gated_step",   0, 1,   1, 0, 0, 0);
        add_dir(4332, 1, "s_gated_fs2",    0, 0,   1, 0, 0, 1);
        add_dir(4333, 1, "s_gated_fs2_w",  0, 0,   1, 0, 0, 0);

        // Reset held three cycles with the enable high.
        repeat (3) tick(1'b1, 1'b1);
        // Continuous enable: several default lines, almost three small frames.
        repeat (1800) tick(1'b0, 1'b1);
        // Enable one clock in four for two small frames.
        for (int k = 0; k < 4864; k++) tick(1'b0, (k % 4) == 0);

        // Run to small-mode row 14, column 22: inside both sync pulses.
        n = 0;
        while (p_s != 470 && n < 1000) begin
            tick(1'b0, 1'b1);
            n++;
        end
        check("reach_mid_frame", n < 1000, $sformatf("gave up after %0d cycles, required < 1000", n));
        add_dir(cyc, 1, "s_pre_rst_sync", 0, 0, 0, 1, 1, 0);

        tick(1'b1, 1'b1);
        add_dir(cyc, 0, "mid_rst_d", 0, 0, 0, 1, 1, 0);
        add_dir(cyc, 1, "mid_rst_s", 0, 0, 0, 0, 0, 0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        add_dir(cyc, 0, "restart_d", 0, 0, 1, 1, 1, 1);
        add_dir(cyc, 1, "restart_s", 0, 0, 1, 0, 0, 1);
        tick(1'b0, 1'b1);
        add_dir(cyc, 1, "restart_next_s", 0, 1, 1, 0, 0, 0);
        repeat (700) tick(1'b0, 1'b1);

        @(negedge clk);
        #1;
        check("scoreboard_drained", (mdl_q.size() == 0) && (dir_q.size() == 0),
              $sformatf("model entries left %0d, directed left %0d, required 0 and 0", mdl_q.size(), dir_q.size()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
